rx_frame_dispatch: RTL and testbench
====================================

// Module: rx_frame_dispatch
// PURPOSE
//  Parametrised receive-side frame parser and dispatcher for the station bus. After the MAC marks a
//  frame complete, one FSM reads the RX buffer, checks CRC and destination, decodes header fields
//  (DA, FC, MODE, ADDR, LEN), and streams payload bytes to one of NUM_CH destination write ports.
//  A single buffer read master; no OR-combined read ports.
// PARAMETERS
//  NUM_CH      3      number of destination write channels (1..8)
//  ADDR_BYTES  3      header ADDR field length in bytes; ADDR_W = 8*ADDR_BYTES
//  BUF_AW      11     RX buffer address width; BUF_DEPTH = 2**BUF_AW
//  MODE_RESET  8'hA5  MODE value that requests card reset (no payload writes)
//  BCAST_DA    8'hFF  broadcast destination address, always accepted
// PORTS
//  clk           in   1              system clock
//  reset         in   1              synchronous, active-high reset
//  ini_done      in   1              frames ignored while low
//  rx_start      in   1              pulse: MAC begins writing a new frame into buffer
//  rx_done       in   1              pulse: frame complete in buffer
//  rx_crc_rslt   in   2              00 pending, 01 pass, 10 fail, 11 treated as fail
//  rack_id       in   3              local rack id
//  slot_id       in   4              local slot id; local DA = {1'b0,rack_id,slot_id}
//  rx_buf_rden   out  1              buffer read enable
//  rx_buf_raddr  out  BUF_AW         buffer read address
//  rx_buf_rdata  in   8              buffer data, valid 1 cycle after rden
//  ch_wren       out  NUM_CH         one-hot payload write strobe
//  ch_waddr      out  ADDR_W         write address, shared by all channels
//  ch_wdata      out  8              write data, shared by all channels
//  rx_mode       out  8              MODE of last accepted frame
//  rx_addr       out  ADDR_W         ADDR of last accepted frame
//  rx_flag       out  1              1-cycle pulse: accepted frame fully dispatched
//  crc_err       out  1              1-cycle pulse: CRC fail
//  len_err       out  1              1-cycle pulse: LEN overruns buffer or MODE selects no channel
//  abort_err     out  1              1-cycle pulse: rx_start arrived while busy
//  card_reset    out  1              1-cycle pulse: accepted frame with MODE == MODE_RESET
//  busy          out  1              high in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE; rx_mode/rx_addr hold last accepted value afterwards.
//  - Buffer layout: [0]DA [1]FC [2]MODE [3..]ADDR big-endian, then LEN (2 B, big-endian), payload.
//  - FSM: IDLE -(rx_done & ini_done)-> CRC_WAIT -(01)-> HDR -> PAYLOAD -> DONE -> IDLE.
//    CRC_WAIT -(10/11)-> crc_err, IDLE. rx_done while ini_done=0: dropped silently.
//  - HDR: reads 5+ADDR_BYTES bytes at 1 read/cycle, pipelined, 1-cycle read latency.
//    DA not local and not BCAST_DA -> IDLE, no pulse. Channel = MODE[2:0]; >= NUM_CH -> len_err.
//  - LEN check: 5+ADDR_BYTES+LEN > BUF_DEPTH -> len_err, IDLE, zero writes.
//  - PAYLOAD: byte k written at ch_waddr = ADDR+k (mod 2**ADDR_W), one byte per cycle after
//    first read; LEN=0 goes straight to DONE. MODE_RESET: card_reset pulse, no writes.
//  - DONE: rx_mode/rx_addr update and rx_flag pulses same cycle, 1 cycle after last ch_wren.
//  - rx_start while busy (any non-IDLE state): abort_err, ch_wren forced 0 that cycle, IDLE;
//    rx_start & rx_done same cycle in IDLE: rx_done wins. rx_done while busy: ignored.
// CONFIGURATION
//  RX_FRAME_STATS_EN defined: adds outputs stat_ok, stat_crc, stat_drop (16 b each, saturating,
//  cleared by reset) counting rx_flag, crc_err, and len_err|abort_err|DA-mismatch events.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package rx_bus_pkg: FSM state enum, header byte offsets, CRC result codes, HDR_LEN function.
//  Sub-module rx_buf_reader: address counter + rden/data-valid 1-cycle pipeline; FSM in top.
// TESTING
//  - ini_done=1, DA={0,3'd2,4'd5}, MODE=1, ADDR=24'h000100, LEN=4, CRC 01 -> ch_wren=3'b010
//    at 0x100..0x103 with payload bytes, rx_flag once, rx_addr=24'h000100.
//  - Same frame, rx_crc_rslt=10 -> crc_err once, no ch_wren, rx_flag 0.
//  - ADDR=24'hFFFFFE, LEN=4 -> waddr FFFFFE, FFFFFF, 000000, 000001.
//  - LEN=16'h0800 (BUF_AW=11) -> len_err, zero writes; MODE=7 with NUM_CH=3 -> len_err.
//  - rx_start after 2 payload writes -> abort_err, no further ch_wren, busy 0 next cycle.
//  - DA=8'h11 mismatch -> no outputs; BCAST_DA with MODE=MODE_RESET -> card_reset, rx_flag.

Source files
------------

// File: rtl/rx_bus_pkg.sv
// rx_bus_pkg: shared FSM states, header layout and CRC codes for the RX frame dispatcher
package rx_bus_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CRC_WAIT, S_HDR, S_PAYLOAD, S_DONE} state_e;
  localparam int OFS_DA = 0;
  localparam int OFS_MODE = 2;
  localparam int OFS_ADDR = 3;
  localparam logic [1:0] CRC_PASS = 2'b01;
  localparam int CRC_FAIL_BIT = 1;
  function automatic int hdr_len(input int addr_bytes);
    return 5 + addr_bytes;
  endfunction
endpackage

// File: rtl/rx_frame_dispatch_if.sv
// rx_frame_dispatch_if: RX buffer read port plus shared payload write port
interface rx_frame_dispatch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 24,
  parameter int BUF_AW = 11
);
  logic              rx_buf_rden;
  logic [BUF_AW-1:0] rx_buf_raddr;
  logic [7:0]        rx_buf_rdata;
  logic [NUM_CH-1:0] ch_wren;
  logic [ADDR_W-1:0] ch_waddr;
  logic [7:0]        ch_wdata;
  modport master(output rx_buf_rden, rx_buf_raddr, ch_wren, ch_waddr, ch_wdata, input rx_buf_rdata);
  modport slave(input rx_buf_rden, rx_buf_raddr, ch_wren, ch_waddr, ch_wdata, output rx_buf_rdata);
endinterface

// File: rtl/rx_frame_dispatch_reader.sv
// rx_buf_reader: sequential buffer address counter with 1-cycle read-data-valid pipeline
module rx_buf_reader #(
  parameter int BUF_AW = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld,
  input  logic [15:0]       n,
  output logic              rden,
  output logic [BUF_AW-1:0] raddr,
  output logic              dvalid,
  output logic [BUF_AW-1:0] didx
);
  logic [15:0]       cnt_q, cnt_d;
  logic [BUF_AW-1:0] addr_q, addr_d, didx_q, didx_d;
  logic              dvalid_q, dvalid_d;
  assign raddr = addr_q;
  assign dvalid = dvalid_q;
  assign didx = didx_q;
  // issue one read per cycle while reads remain; clr rewinds to byte 0 and kills the pipeline
  always_comb begin
    rden = cnt_q != '0 && !clr;
    addr_d = clr ? '0 : addr_q + BUF_AW'(rden);
    cnt_d = ld ? n : clr ? '0 : cnt_q - 16'(rden);
    dvalid_d = rden;
    didx_d = rden ? addr_q : didx_q;
  end
  // reader state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      addr_q <= '0;
      didx_q <= '0;
      dvalid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      didx_q <= didx_d;
      dvalid_q <= dvalid_d;
    end
  end
endmodule

// File: rtl/rx_frame_dispatch.sv
// rx_frame_dispatch: parses a completed RX frame and streams its payload to one of NUM_CH ports (optional RX_FRAME_STATS_EN adds event counters)
module rx_frame_dispatch
  import rx_bus_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ADDR_BYTES = 3,
  parameter int BUF_AW = 11,
  parameter logic [7:0] MODE_RESET = 8'hA5,
  parameter logic [7:0] BCAST_DA = 8'hFF,
  localparam int ADDR_W = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ini_done,
  input  logic              rx_start,
  input  logic              rx_done,
  input  logic [1:0]        rx_crc_rslt,
  input  logic [2:0]        rack_id,
  input  logic [3:0]        slot_id,
  rx_frame_dispatch_if.master bus,
  output logic [7:0]        rx_mode,
  output logic [ADDR_W-1:0] rx_addr,
  output logic              rx_flag,
  output logic              crc_err,
  output logic              len_err,
  output logic              abort_err,
  output logic              card_reset,
  output logic              busy
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [15:0]       stat_ok,
  output logic [15:0]       stat_crc,
  output logic [15:0]       stat_drop
`endif
);
  localparam int HDR_LEN = hdr_len(ADDR_BYTES);
  localparam int BUF_DEPTH = 2 ** BUF_AW;
  state_e            state_q, state_d;
  logic [7:0]        da_q, da_d, mode_q, mode_d, len_hi_q, len_hi_d, rx_mode_q, rx_mode_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d, waddr_q, waddr_d, rx_addr_q, rx_addr_d;
  logic [15:0]       wr_left_q, wr_left_d, len, rd_n;
  logic              rd_ld, rd_clr, dvalid, wren, da_ok, len_ovf, chan_ok, hdr_last;
  logic [BUF_AW-1:0] didx;
  int                idx;
  rx_buf_reader #(.BUF_AW(BUF_AW)) u_reader (
    .clk(clk), .reset(reset), .clr(rd_clr), .ld(rd_ld), .n(rd_n),
    .rden(bus.rx_buf_rden), .raddr(bus.rx_buf_raddr), .dvalid(dvalid), .didx(didx)
  );
  assign busy = state_q != S_IDLE;
  assign abort_err = rx_start && busy;
  assign rd_clr = !busy || abort_err;
  assign idx = int'(didx);
  assign len = {len_hi_q, bus.rx_buf_rdata};
  assign da_ok = da_q == {1'b0, rack_id, slot_id} || da_q == BCAST_DA;
  assign len_ovf = 32'(HDR_LEN) + 32'(len) > 32'(BUF_DEPTH);
  assign chan_ok = 32'(mode_q[2:0]) < 32'(NUM_CH);
  assign hdr_last = state_q == S_HDR && dvalid && idx == HDR_LEN - 1;
  assign bus.ch_wren = wren ? NUM_CH'(1) << mode_q[2:0] : '0;
  assign bus.ch_waddr = waddr_q;
  assign bus.ch_wdata = bus.rx_buf_rdata;
  assign rx_mode = rx_mode_q;
  assign rx_addr = rx_addr_q;
  // frame FSM: header capture, accept/reject decision, payload dispatch; abort overrides all
  always_comb begin
    state_d = state_q;
    da_d = da_q;
    mode_d = mode_q;
    len_hi_d = len_hi_q;
    hdr_addr_d = hdr_addr_q;
    waddr_d = waddr_q;
    wr_left_d = wr_left_q;
    rx_mode_d = rx_mode_q;
    rx_addr_d = rx_addr_q;
    rd_ld = 1'b0;
    rd_n = '0;
    wren = 1'b0;
    rx_flag = 1'b0;
    crc_err = 1'b0;
    len_err = 1'b0;
    card_reset = 1'b0;
    if (abort_err) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: state_d = rx_done && ini_done ? S_CRC_WAIT : S_IDLE;
      S_CRC_WAIT: begin
        rd_ld = rx_crc_rslt == CRC_PASS;
        rd_n = 16'(HDR_LEN);
        crc_err = rx_crc_rslt[CRC_FAIL_BIT];
        state_d = rd_ld ? S_HDR : crc_err ? S_IDLE : S_CRC_WAIT;
      end
      S_HDR: begin
        if (dvalid) begin
          da_d = idx == OFS_DA ? bus.rx_buf_rdata : da_q;
          mode_d = idx == OFS_MODE ? bus.rx_buf_rdata : mode_q;
          hdr_addr_d = idx >= OFS_ADDR && idx < OFS_ADDR + ADDR_BYTES ? ADDR_W'({hdr_addr_q, bus.rx_buf_rdata}) : hdr_addr_q;
          len_hi_d = idx == HDR_LEN - 2 ? bus.rx_buf_rdata : len_hi_q;
        end
        if (hdr_last) begin
          if (!da_ok) state_d = S_IDLE;
          else if (len_ovf || (mode_q != MODE_RESET && !chan_ok)) begin
            len_err = 1'b1;
            state_d = S_IDLE;
          end else if (mode_q == MODE_RESET) begin
            card_reset = 1'b1;
            state_d = S_DONE;
          end else if (len == '0) state_d = S_DONE;
          else begin
            state_d = S_PAYLOAD;
            rd_ld = 1'b1;
            rd_n = len;
            wr_left_d = len;
            waddr_d = hdr_addr_q;
          end
        end
      end
      S_PAYLOAD: begin
        wren = dvalid;
        if (dvalid) begin
          waddr_d = waddr_q + ADDR_W'(1);
          wr_left_d = wr_left_q - 16'd1;
          state_d = wr_left_q == 16'd1 ? S_DONE : S_PAYLOAD;
        end
      end
      S_DONE: begin
        rx_flag = 1'b1;
        rx_mode_d = mode_q;
        rx_addr_d = hdr_addr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // FSM and header registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      da_q <= '0;
      mode_q <= '0;
      len_hi_q <= '0;
      hdr_addr_q <= '0;
      waddr_q <= '0;
      wr_left_q <= '0;
      rx_mode_q <= '0;
      rx_addr_q <= '0;
    end else begin
      state_q <= state_d;
      da_q <= da_d;
      mode_q <= mode_d;
      len_hi_q <= len_hi_d;
      hdr_addr_q <= hdr_addr_d;
      waddr_q <= waddr_d;
      wr_left_q <= wr_left_d;
      rx_mode_q <= rx_mode_d;
      rx_addr_q <= rx_addr_d;
    end
  end
`ifdef RX_FRAME_STATS_EN
  logic [15:0] stat_ok_q, stat_ok_d, stat_crc_q, stat_crc_d, stat_drop_q, stat_drop_d;
  logic        drop_ev;
  assign drop_ev = len_err || abort_err || (hdr_last && !da_ok);
  assign stat_ok = stat_ok_q;
  assign stat_crc = stat_crc_q;
  assign stat_drop = stat_drop_q;
  // saturating event counters
  always_comb begin
    stat_ok_d = stat_ok_q + 16'(rx_flag && !(&stat_ok_q));
    stat_crc_d = stat_crc_q + 16'(crc_err && !(&stat_crc_q));
    stat_drop_d = stat_drop_q + 16'(drop_ev && !(&stat_drop_q));
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ok_q <= '0;
      stat_crc_q <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_ok_q <= stat_ok_d;
      stat_crc_q <= stat_crc_d;
      stat_drop_q <= stat_drop_d;
    end
  end
`endif
endmodule

// File: tb/tb_rx_frame_dispatch.sv
// tb_rx_frame_dispatch: randomized scoreboard bench for rx_frame_dispatch
module tb_rx_frame_dispatch;
  localparam int NUM_CH = 3, AB = 3, AW = 24, BAW = 11, DEPTH = 2048, HL = 5 + AB;
  localparam logic [7:0] LOCAL_DA = 8'h25;
  logic clk = 0, reset = 1, ini_done = 0, rx_start = 0, rx_done = 0;
  logic [1:0] rx_crc_rslt = 0;
  logic [2:0] rack_id = 3'd2;
  logic [3:0] slot_id = 4'd5;
  logic [7:0] rx_mode;
  logic [AW-1:0] rx_addr;
  logic rx_flag, crc_err, len_err, abort_err, card_reset, busy;
  rx_frame_dispatch_if #(.NUM_CH(NUM_CH), .ADDR_W(AW), .BUF_AW(BAW)) bus ();
  rx_frame_dispatch #(.NUM_CH(NUM_CH), .ADDR_BYTES(AB), .BUF_AW(BAW)) dut (
    .clk(clk), .reset(reset), .ini_done(ini_done), .rx_start(rx_start), .rx_done(rx_done),
    .rx_crc_rslt(rx_crc_rslt), .rack_id(rack_id), .slot_id(slot_id), .bus(bus),
    .rx_mode(rx_mode), .rx_addr(rx_addr), .rx_flag(rx_flag), .crc_err(crc_err),
    .len_err(len_err), .abort_err(abort_err), .card_reset(card_reset), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (bus.rx_buf_rden) bus.rx_buf_rdata <= mem[bus.rx_buf_raddr];
  typedef struct packed {logic [NUM_CH-1:0] en; logic [AW-1:0] a; logic [7:0] d;} wr_t;
  wr_t exp_wr[$];
  int checks = 0, errors = 0;
  int n_wr, n_flag, n_crc, n_len, n_abort, n_card;
  logic [7:0] last_mode = 0;
  logic [AW-1:0] last_addr = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (bus.ch_wren != '0) begin
        n_wr++;
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'(bus.ch_wren), 64'(0));
        else begin
          e = exp_wr.pop_front();
          chk("wr", 64'({bus.ch_wren, bus.ch_waddr, bus.ch_wdata}), 64'(e));
        end
      end
      n_flag += int'(rx_flag);
      n_crc += int'(crc_err);
      n_len += int'(len_err);
      n_abort += int'(abort_err);
      n_card += int'(card_reset);
    end
  end
  task automatic run_frame(input logic [7:0] da, mode, input logic [AW-1:0] addr, input logic [15:0] len,
                           input logic [1:0] cr, input logic ini, input int abort_after, input logic st);
    int e_crc = 0, e_len = 0, e_card = 0, e_flag = 0, e_abort = 0, t = 0;
    mem[0] = da; mem[1] = 8'($urandom); mem[2] = mode;
    for (int i = 0; i < AB; i++) mem[3 + i] = addr[8 * (AB - 1 - i) +: 8];
    mem[HL - 2] = len[15:8]; mem[HL - 1] = len[7:0];
    for (int k = 0; k < int'(len) && HL + k < DEPTH; k++) mem[HL + k] = 8'($urandom);
    if (ini) begin
      if (cr != 2'b01) e_crc = 1;
      else if (da == LOCAL_DA || da == 8'hFF) begin
        if (HL + int'(len) > DEPTH) e_len = 1;
        else if (mode == 8'hA5) begin e_card = 1; e_flag = 1; end
        else if (mode % 8 >= NUM_CH) e_len = 1;
        else begin
          for (int k = 0; k < int'(len); k++)
            if (abort_after < 0 || k < abort_after)
              exp_wr.push_back({NUM_CH'(1 << (mode % 8)), AW'(addr + k), mem[HL + k]});
          if (abort_after < 0) e_flag = 1; else e_abort = 1;
        end
      end
    end
    if (e_flag) begin last_mode = mode; last_addr = addr; end
    n_wr = 0; n_flag = 0; n_crc = 0; n_len = 0; n_abort = 0; n_card = 0;
    ini_done = ini; rx_crc_rslt = cr; rx_done = 1; rx_start = st;
    tick;
    rx_done = 0; rx_start = 0;
    if (abort_after >= 0) begin
      while (n_wr < abort_after && t < 5000) begin tick; t++; end
      rx_start = 1;
      tick;
      rx_start = 0;
      chk("abort_busy", 64'(busy), 64'(0));
    end
    t = 0;
    while (busy && t < 5000) begin tick; t++; end
    chk("frame_done_busy", 64'(busy), 64'(0));
    tick; tick;
    chk("crc_err_cnt", 64'(n_crc), 64'(e_crc));
    chk("len_err_cnt", 64'(n_len), 64'(e_len));
    chk("abort_cnt", 64'(n_abort), 64'(e_abort));
    chk("card_reset_cnt", 64'(n_card), 64'(e_card));
    chk("rx_flag_cnt", 64'(n_flag), 64'(e_flag));
    chk("wr_missing", 64'(exp_wr.size()), 64'(0));
    chk("rx_mode_addr", 64'({rx_mode, rx_addr}), 64'({last_mode, last_addr}));
    exp_wr.delete();
  endtask
  initial begin
    logic [7:0] da, mode;
    logic [AW-1:0] addr;
    logic [15:0] len;
    logic [1:0] cr;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    repeat (3) tick;
    @(negedge clk);
    chk("reset_outs", 64'({bus.rx_buf_rden, bus.rx_buf_raddr, bus.ch_wren, bus.ch_waddr, rx_mode, rx_addr,
                           rx_flag, crc_err, len_err, abort_err, card_reset, busy}), 64'(0));
    reset = 0;
    tick;
    run_frame(LOCAL_DA, 8'h01, 24'h000100, 16'd4, 2'b01, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h01, 24'h000100, 16'd4, 2'b10, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h02, 24'hFFFFFE, 16'd4, 2'b01, 1, -1, 1);
    run_frame(LOCAL_DA, 8'h01, 24'h000200, 16'h0800, 2'b01, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h07, 24'h000300, 16'd4, 2'b01, 1, -1, 0);
    run_frame(8'hFF, 8'h00, 24'h123456, 16'd2040, 2'b01, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h00, 24'h000400, 16'd2041, 2'b01, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h01, 24'h000500, 16'd6, 2'b01, 1, 2, 0);
    run_frame(8'h11, 8'h01, 24'h000600, 16'd4, 2'b01, 1, -1, 0);
    run_frame(8'hFF, 8'hA5, 24'hABCDEF, 16'd3, 2'b01, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h00, 24'h000700, 16'd0, 2'b01, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h02, 24'h000800, 16'd2, 2'b11, 1, -1, 0);
    run_frame(LOCAL_DA, 8'h02, 24'h000900, 16'd2, 2'b01, 0, -1, 0);
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      da = r < 5 ? LOCAL_DA : r < 7 ? 8'hFF : r < 8 ? 8'h11 : 8'($urandom);
      r = $urandom_range(0, 9);
      mode = r < 6 ? 8'($urandom_range(0, 2)) : r == 6 ? 8'hA5 : r == 7 ? 8'h07 : 8'($urandom);
      addr = $urandom_range(0, 3) == 0 ? AW'(24'hFFFFF0 + $urandom_range(0, 15)) : AW'($urandom);
      r = $urandom_range(0, 19);
      len = r < 17 ? 16'($urandom_range(0, 24)) : r == 17 ? 16'h0800 : 16'($urandom);
      cr = $urandom_range(0, 9) < 8 ? 2'b01 : 2'($urandom_range(2, 3));
      run_frame(da, mode, addr, len, cr, 1, -1, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
